char_bbox_locate: RTL and testbench
===================================

CHAR_BBOX_LOCATE -- requirements
Module: char_bbox_locate

Interface
REQ-001 Parameter MIN_HITS, default 64: minimum thresholded-pixel count for a valid box.
REQ-002 Parameter MIN_H, default 20: minimum box height (char_down - char_up) for a valid box.
REQ-003 clk  in  1  pixel clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 i_hs, i_vs, i_de  in  1 each  video sync/enable; i_vs high during the active frame.
REQ-006 i_x, i_y  in  12 each  current pixel position.
REQ-007 i_data  in  24  RGB pixel; i_th  in  1  binarized pixel (1 = character stroke).
REQ-008 roi_left, roi_right, roi_up, roi_down  in  12 each  single-character search window, inclusive bounds.
REQ-009 char_up, char_down, char_left, char_right  out  12 each  latched character bounding box.
REQ-010 row_scanf_line1, row_scanf_line2  out  12 each  horizontal scan rows for the feature scanner.
REQ-011 bbox_valid  out  1  the latched box came from the most recent completed frame.
REQ-012 o_hs, o_vs, o_de, o_th  out  1 each; o_x, o_y  out  12 each; o_data  out  24  video delayed one cycle.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCUM, LATCH.
REQ-014 Transitions: IDLE->ACCUM on i_vs rising edge (i_vs=1, previous i_vs=0); ACCUM->LATCH on i_vs falling edge; LATCH->IDLE after exactly one cycle.
REQ-015 On the IDLE->ACCUM edge: min_x, min_y := 12'hFFF; max_x, max_y := 0; hit_cnt := 0.
REQ-016 In ACCUM, a pixel is a hit when i_de=1, i_th=1, roi_left<=i_x<=roi_right, and roi_up<=i_y<=roi_down.
REQ-017 On a hit, min/max x and y SHALL update with that pixel in the same cycle.
REQ-018 On a hit, hit_cnt (16 bit) SHALL increment, saturating at 16'hFFFF.
REQ-019 An inverted ROI (left>right or up>down) yields zero hits; no special handling.
REQ-020 In LATCH, the frame is valid iff hit_cnt >= MIN_HITS and (max_y - min_y) >= MIN_H, using 12-bit unsigned arithmetic.
REQ-021 Valid frame, outputs at the LATCH clock edge:
  - char_left=min_x, char_right=max_x, char_up=min_y, char_down=max_y;
  - off = (h>>2)+(h>>4), with h = max_y-min_y;
  - row_scanf_line1 = min_y+off; row_scanf_line2 = max_y-off;
  - bbox_valid := 1.
REQ-022 Invalid frame: box and line outputs hold their previous values; bbox_valid := 0.
REQ-023 Latency: outputs are updated 2 cycles after the i_vs falling edge sample and stay stable for the whole next frame.
REQ-024 A pixel coinciding with the i_vs falling edge SHALL NOT be accumulated.
REQ-025 An i_vs pulse shorter than one cycle pair (rise then fall on consecutive cycles) SHALL still pass ACCUM->LATCH and evaluate as zero hits.
REQ-026 Passthrough: o_hs/o_vs/o_de/o_x/o_y/o_th/o_data = inputs registered once.

Reset
REQ-027 On rst: state := IDLE; all box outputs, row_scanf lines, and accumulators := 0; min registers := 12'hFFF; bbox_valid := 0; all passthrough outputs := 0.
REQ-028 Reset asserted mid-frame discards the partial frame; after reset the block waits for the next i_vs rising edge, so a frame already in progress is never latched.

Configuration
REQ-029 Macro CHAR_BBOX_OVERLAY_EN controls a debug overlay on o_data.
REQ-030 With CHAR_BBOX_OVERLAY_EN defined, while bbox_valid=1, o_data = 24'hFF0000 for any pixel on the latched box perimeter. A pixel is on the perimeter when (i_x == char_left or char_right, with char_up<=i_y<=char_down) or (i_y == char_up or char_down, with char_left<=i_x<=char_right).
REQ-031 With CHAR_BBOX_OVERLAY_EN defined, o_data = 24'h00FF00 for pixels on row_scanf_line1 or row_scanf_line2 inside the box; otherwise o_data = delayed i_data.
REQ-032 Without CHAR_BBOX_OVERLAY_EN, o_data is always delayed i_data and no overlay logic is synthesized.

Verification
REQ-033 Frame setup: ROI 100..160 x 200..300; solid block i_th=1 at x 110..139, y 210..289 (2400 hits). Required: box 110/139/210/289, h=79, off=23, line1=233, line2=266, bbox_valid=1 two cycles after i_vs falls.
REQ-034 Next frame with only 40 hits -> bbox_valid=0, box and lines unchanged from REQ-033 values.
REQ-035 Hits placed outside the ROI (x=99 and x=161) -> ignored; box equals the in-ROI extent only.
REQ-036 rst pulsed at mid-frame y=250 -> all outputs 0 and the remainder of that frame ignored; the next full frame latches correctly.
REQ-037 Inverted ROI (left=200, right=100) -> bbox_valid=0 at frame end.
REQ-038 With CHAR_BBOX_OVERLAY_EN, after REQ-033: o_data at (110,250)=FF0000 and at (120,233)=00FF00; without the macro, both equal delayed i_data.

Source files
------------

// File: rtl/char_bbox_locate.sv
// char_bbox_locate: per-frame bounding box of thresholded pixels inside an ROI, plus scan-row placement.
// Define CHAR_BBOX_OVERLAY_EN to draw the latched box and scan rows onto o_data.
module char_bbox_locate #(
   parameter int MIN_HITS = 64,
   parameter int MIN_H    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_hs,
   input  logic        i_vs,
   input  logic        i_de,
   input  logic [11:0] i_x,
   input  logic [11:0] i_y,
   input  logic [23:0] i_data,
   input  logic        i_th,
   input  logic [11:0] roi_left,
   input  logic [11:0] roi_right,
   input  logic [11:0] roi_up,
   input  logic [11:0] roi_down,
   output logic [11:0] char_up,
   output logic [11:0] char_down,
   output logic [11:0] char_left,
   output logic [11:0] char_right,
   output logic [11:0] row_scanf_line1,
   output logic [11:0] row_scanf_line2,
   output logic        bbox_valid,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic        o_th,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic [23:0] o_data
);

   typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

   localparam logic [15:0] MinHitsW = 16'(MIN_HITS);
   localparam logic [11:0] MinHW    = 12'(MIN_H);

   state_t      state, next_state;
   logic        vs_prev;
   logic [11:0] min_x, max_x, min_y, max_y;
   logic [15:0] hit_cnt;
   logic        vs_rise, vs_fall, in_roi, hit, frame_ok;
   logic [11:0] box_h, line_off;
   logic [23:0] data_next;

   assign vs_rise  = i_vs & ~vs_prev;
   assign vs_fall  = ~i_vs & vs_prev;
   assign in_roi   = (i_x >= roi_left) && (i_x <= roi_right) &&
                     (i_y >= roi_up)   && (i_y <= roi_down);
   assign hit      = (state == ACCUM) && !vs_fall && i_de && i_th && in_roi;
   assign box_h    = max_y - min_y;
   assign line_off = {2'b00, box_h[11:2]} + {4'b0000, box_h[11:4]};
   assign frame_ok = (hit_cnt >= MinHitsW) && (box_h >= MinHW);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (vs_rise) next_state = ACCUM;
         ACCUM:   if (vs_fall) next_state = LATCH;
         LATCH:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // vs_prev tracks i_vs even in reset, so a frame already running when reset
   // releases never looks like a fresh rising edge.
   always_ff @(posedge clk) begin
      vs_prev <= i_vs;
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         min_x   <= 12'hFFF;
         min_y   <= 12'hFFF;
         max_x   <= 12'h000;
         max_y   <= 12'h000;
         hit_cnt <= 16'h0000;
      end else if (state == IDLE && vs_rise) begin
         min_x   <= 12'hFFF;
         min_y   <= 12'hFFF;
         max_x   <= 12'h000;
         max_y   <= 12'h000;
         hit_cnt <= 16'h0000;
      end else if (hit) begin
         if (i_x < min_x) min_x <= i_x;
         if (i_x > max_x) max_x <= i_x;
         if (i_y < min_y) min_y <= i_y;
         if (i_y > max_y) max_y <= i_y;
         if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end
   end

   // A rejected frame keeps the previous box so the scanner has stable rows.
   always_ff @(posedge clk) begin
      if (rst) begin
         char_up         <= 12'h000;
         char_down       <= 12'h000;
         char_left       <= 12'h000;
         char_right      <= 12'h000;
         row_scanf_line1 <= 12'h000;
         row_scanf_line2 <= 12'h000;
         bbox_valid      <= 1'b0;
      end else if (state == LATCH) begin
         bbox_valid <= frame_ok;
         if (frame_ok) begin
            char_up         <= min_y;
            char_down       <= max_y;
            char_left       <= min_x;
            char_right      <= max_x;
            row_scanf_line1 <= min_y + line_off;
            row_scanf_line2 <= max_y - line_off;
         end
      end
   end

`ifdef CHAR_BBOX_OVERLAY_EN
   logic in_box, on_col, on_row, on_line;

   assign in_box  = (i_x >= char_left) && (i_x <= char_right) &&
                    (i_y >= char_up)   && (i_y <= char_down);
   assign on_col  = (i_x == char_left || i_x == char_right) && (i_y >= char_up) && (i_y <= char_down);
   assign on_row  = (i_y == char_up || i_y == char_down) && (i_x >= char_left) && (i_x <= char_right);
   assign on_line = (i_y == row_scanf_line1 || i_y == row_scanf_line2) && in_box;

   always_comb begin
      data_next = i_data;
      if (bbox_valid && (on_col || on_row)) data_next = 24'hFF0000;
      else if (bbox_valid && on_line)       data_next = 24'h00FF00;
   end
`else
   assign data_next = i_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         o_hs   <= 1'b0;
         o_vs   <= 1'b0;
         o_de   <= 1'b0;
         o_th   <= 1'b0;
         o_x    <= 12'h000;
         o_y    <= 12'h000;
         o_data <= 24'h000000;
      end else begin
         o_hs   <= i_hs;
         o_vs   <= i_vs;
         o_de   <= i_de;
         o_th   <= i_th;
         o_x    <= i_x;
         o_y    <= i_y;
         o_data <= data_next;
      end
   end

endmodule

// File: tb/tb_char_bbox_locate.sv
// Self-checking bench for char_bbox_locate: scoreboard of expected latched boxes per frame,
// plus reset, passthrough and overlay checks (overlay expectations follow CHAR_BBOX_OVERLAY_EN).
module tb_char_bbox_locate;

   typedef struct packed {
      logic        valid;
      logic [11:0] up, down, left, right, l1, l2;
   } box_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_hs, i_vs, i_de, i_th;
   logic [11:0] i_x, i_y;
   logic [23:0] i_data;
   logic [11:0] roi_left, roi_right, roi_up, roi_down;
   logic [11:0] char_up, char_down, char_left, char_right;
   logic [11:0] row_scanf_line1, row_scanf_line2;
   logic        bbox_valid;
   logic        o_hs, o_vs, o_de, o_th;
   logic [11:0] o_x, o_y;
   logic [23:0] o_data;

   int checks = 0;
   int errors = 0;

   box_t sb[$];
   box_t m_box;
   logic m_accum;
   logic [11:0] m_minx, m_maxx, m_miny, m_maxy;
   int m_cnt;

   char_bbox_locate dut (
      .clk(clk), .rst(rst),
      .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y),
      .i_data(i_data), .i_th(i_th),
      .roi_left(roi_left), .roi_right(roi_right), .roi_up(roi_up), .roi_down(roi_down),
      .char_up(char_up), .char_down(char_down), .char_left(char_left), .char_right(char_right),
      .row_scanf_line1(row_scanf_line1), .row_scanf_line2(row_scanf_line2),
      .bbox_valid(bbox_valid),
      .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_th(o_th),
      .o_x(o_x), .o_y(o_y), .o_data(o_data)
   );

   always #5 clk = ~clk;

   function automatic box_t dut_box();
      return {bbox_valid, char_up, char_down, char_left, char_right, row_scanf_line1, row_scanf_line2};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_box   = '0;
      m_accum = 1'b0;
   endtask

   task automatic start_frame();
      i_vs = 1'b1;
      i_de = 1'b0;
      m_accum = 1'b1;
      m_minx = 12'hFFF; m_miny = 12'hFFF; m_maxx = 12'h000; m_maxy = 12'h000; m_cnt = 0;
      tick();
   endtask

   task automatic drive_pixel(input logic [11:0] x, input logic [11:0] y, input logic th);
      i_de = 1'b1; i_th = th; i_x = x; i_y = y; i_data = 24'($urandom);
      if (m_accum && th && x >= roi_left && x <= roi_right && y >= roi_up && y <= roi_down) begin
         if (x < m_minx) m_minx = x;
         if (x > m_maxx) m_maxx = x;
         if (y < m_miny) m_miny = y;
         if (y > m_maxy) m_maxy = y;
         m_cnt++;
      end
      tick();
   endtask

   task automatic drive_block(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            drive_pixel(12'(x), 12'(y), 1'b1);
   endtask

   // Drops i_vs, pushes the expected box and returns bbox_valid seen one edge after the fall.
   task automatic end_frame(output logic early_valid);
      logic [11:0] h, off;
      i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0;
      tick();
      early_valid = bbox_valid;
      if (m_accum) begin
         h   = m_maxy - m_miny;
         off = (h >> 2) + (h >> 4);
         if (m_cnt >= 64 && h >= 12'd20)
            m_box = {1'b1, m_miny, m_maxy, m_minx, m_maxx, 12'(m_miny + off), 12'(m_maxy - off)};
         else
            m_box.valid = 1'b0;
      end
      m_accum = 1'b0;
      sb.push_back(m_box);
      tick();
   endtask

   task automatic test_reset();
      box_t got;
      rst = 1'b1;
      tick(); tick();
      got = dut_box();
      checks++;
      if (got !== box_t'('0)) begin
         errors++; $display("[TB] FAIL reset_box got=%h exp=0", got);
      end
      checks++;
      if ({o_hs, o_vs, o_de, o_th, o_x, o_y, o_data} !== '0) begin
         errors++; $display("[TB] FAIL reset_passthrough got=%h exp=0", {o_hs, o_vs, o_de, o_th, o_x, o_y, o_data});
      end
      rst = 1'b0;
      model_reset();
      tick();
   endtask

   task automatic test_valid_frame();
      box_t got, exp;
      logic early;
      start_frame();
      drive_pixel(12'd105, 12'd205, 1'b0);
      drive_block(110, 139, 210, 289);
      drive_pixel(12'd150, 12'd295, 1'b0);
      end_frame(early);
      checks++;
      if (early !== 1'b0) begin
         errors++; $display("[TB] FAIL latency_early_valid got=%b exp=0", early);
      end
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL valid_frame_box got=%h exp=%h", got, exp);
      end
      checks++;
      if (got !== {1'b1, 12'd210, 12'd289, 12'd110, 12'd139, 12'd233, 12'd266}) begin
         errors++; $display("[TB] FAIL valid_frame_const got=%h exp=1/210/289/110/139/233/266", got);
      end
   endtask

   task automatic test_passthrough();
      logic [63:0] expq[$];
      logic [63:0] exp, got;
      for (int n = 0; n < 6; n++) begin
         i_hs = 1'($urandom); i_de = 1'($urandom); i_th = 1'($urandom);
         i_x = 12'($urandom_range(2000, 4000)); i_y = 12'($urandom_range(2000, 4000));
         i_data = 24'($urandom);
         expq.push_back({i_hs, 1'b0, i_de, i_th, i_x, i_y, i_data});
         tick();
         exp = expq.pop_front();
         got = {o_hs, o_vs, o_de, o_th, o_x, o_y, o_data};
         checks++;
         if (got !== exp) begin
            errors++; $display("[TB] FAIL passthrough_%0d got=%h exp=%h", n, got, exp);
         end
      end
      i_de = 1'b0; i_th = 1'b0;
   endtask

   task automatic test_overlay();
      logic [23:0] d, exp;
      i_de = 1'b1; i_x = 12'd110; i_y = 12'd250; d = 24'h123456; i_data = d;
`ifdef CHAR_BBOX_OVERLAY_EN
      exp = 24'hFF0000;
`else
      exp = d;
`endif
      tick();
      checks++;
      if (o_data !== exp) begin
         errors++; $display("[TB] FAIL overlay_perimeter got=%h exp=%h", o_data, exp);
      end
      i_x = 12'd120; i_y = 12'd233; d = 24'hABCDEF; i_data = d;
`ifdef CHAR_BBOX_OVERLAY_EN
      exp = 24'h00FF00;
`else
      exp = d;
`endif
      tick();
      checks++;
      if (o_data !== exp) begin
         errors++; $display("[TB] FAIL overlay_scanline got=%h exp=%h", o_data, exp);
      end
      i_x = 12'd125; i_y = 12'd250; d = 24'h0F0F0F; i_data = d;
      tick();
      checks++;
      if (o_data !== d) begin
         errors++; $display("[TB] FAIL overlay_interior got=%h exp=%h", o_data, d);
      end
      i_de = 1'b0;
   endtask

   task automatic test_low_hits();
      box_t got, exp;
      logic early;
      start_frame();
      for (int x = 110; x < 150; x++) drive_pixel(12'(x), 12'd220, 1'b1);
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL low_hits_box got=%h exp=%h", got, exp);
      end
      checks++;
      if (got !== {1'b0, 12'd210, 12'd289, 12'd110, 12'd139, 12'd233, 12'd266}) begin
         errors++; $display("[TB] FAIL low_hits_hold got=%h exp=0/210/289/110/139/233/266", got);
      end
   endtask

   task automatic test_outside_roi();
      box_t got, exp;
      logic early;
      start_frame();
      drive_pixel(12'd99, 12'd250, 1'b1);
      drive_block(112, 135, 215, 280);
      drive_pixel(12'd161, 12'd230, 1'b1);
      drive_pixel(12'd120, 12'd301, 1'b1);
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL outside_roi_box got=%h exp=%h", got, exp);
      end
      checks++;
      if ({got.left, got.right, got.up, got.down} !== {12'd112, 12'd135, 12'd215, 12'd280}) begin
         errors++; $display("[TB] FAIL outside_roi_extent got=%h exp=112/135/215/280", {got.left, got.right, got.up, got.down});
      end
   endtask

   task automatic test_short_pulse();
      box_t got, exp;
      logic early;
      start_frame();
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL short_pulse_box got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_reset_mid_frame();
      box_t got, exp;
      logic early;
      start_frame();
      drive_block(110, 139, 210, 249);
      rst = 1'b1; i_de = 1'b0;
      tick();
      model_reset();
      got = dut_box();
      checks++;
      if (got !== box_t'('0)) begin
         errors++; $display("[TB] FAIL mid_reset_box got=%h exp=0", got);
      end
      checks++;
      if ({o_hs, o_vs, o_de, o_th, o_x, o_y, o_data} !== '0) begin
         errors++; $display("[TB] FAIL mid_reset_passthrough got=%h exp=0", {o_hs, o_vs, o_de, o_th, o_x, o_y, o_data});
      end
      rst = 1'b0;
      drive_block(110, 139, 250, 289);
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL mid_reset_ignored got=%h exp=%h", got, exp);
      end
      tick();
      start_frame();
      drive_block(110, 139, 210, 289);
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL recovery_frame got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_inverted_roi();
      box_t got, exp;
      logic early;
      roi_left = 12'd200; roi_right = 12'd100;
      start_frame();
      drive_block(110, 139, 210, 289);
      end_frame(early);
      got = dut_box();
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         errors++; $display("[TB] FAIL inverted_roi_box got=%h exp=%h", got, exp);
      end
      checks++;
      if (bbox_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL inverted_roi_valid got=%b exp=0", bbox_valid);
      end
      roi_left = 12'd100; roi_right = 12'd160;
   endtask

   initial begin
      rst = 1'b1;
      i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; i_th = 1'b0;
      i_x = '0; i_y = '0; i_data = '0;
      roi_left = 12'd100; roi_right = 12'd160; roi_up = 12'd200; roi_down = 12'd300;
      model_reset();
      test_reset();
      test_valid_frame();
      test_passthrough();
      test_overlay();
      test_low_hits();
      test_outside_roi();
      test_short_pulse();
      test_reset_mid_frame();
      test_inverted_roi();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
